// File: rtl/spi_adc_responder.sv
// SPI slave that answers like an 8-channel, 12-bit serial ADC. All SPI pins are
// resynchronised into clk_50, so the master's serial clock must be much slower than clk_50.
module spi_adc_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_din,
    output logic        spi_dout,
    output logic        spi_dout_oe,
    input  logic [95:0] sample_data,
    output logic [2:0]  cur_ch,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;

    logic cs_s, sclk_s, din_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    state_e      state_q;
    logic [15:0] sr_q;
    logic [4:0]  rcnt_q;
    logic [2:0]  naddr_q;
    logic [2:0]  cur_ch_q;
    logic        dout_q;
    logic        oe_q;
    logic        done_q;
    logic        err_q;

    logic [11:0] ch_word_d;
    logic [15:0] sr_shift_d;

    // Synchronisers idle high so a pin held high across reset never looks like an edge.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            din_sync_q  <= '1;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi_din};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    always_comb begin
        ch_word_d = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            if (cur_ch_q == 3'(n)) begin
                ch_word_d = sample_data[12*n +: 12];
            end
        end
    end

    assign sr_shift_d = {sr_q[14:0], 1'b0};

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            rcnt_q   <= '0;
            naddr_q  <= '0;
            cur_ch_q <= '0;
            dout_q   <= 1'b0;
            oe_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // sclk activity while deselected is deliberately ignored
                    if (cs_fall) begin
                        sr_q    <= {4'b0000, ch_word_d};
                        dout_q  <= 1'b0;
                        oe_q    <= 1'b1;
                        rcnt_q  <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (rcnt_q != '0) begin
                            err_q <= 1'b1;
                        end
                        oe_q    <= 1'b0;
                        dout_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sclk_rise) begin
                        rcnt_q <= rcnt_q + 5'd1;
                        if (rcnt_q >= 5'd2 && rcnt_q <= 5'd4) begin
                            naddr_q <= {naddr_q[1:0], din_s};
                        end
                        if (rcnt_q == 5'd15) begin
                            done_q   <= 1'b1;
                            cur_ch_q <= naddr_q;
                            state_q  <= HOLD;
                        end
                    end else if (sclk_fall && rcnt_q != '0) begin
                        sr_q   <= sr_shift_d;
                        dout_q <= sr_shift_d[15];
                    end
                end
                HOLD: begin
                    if (cs_rise) begin
                        oe_q    <= 1'b0;
                        dout_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sclk_fall) begin
                        // back-to-back frame: reload from the channel just latched
                        sr_q    <= {4'b0000, ch_word_d};
                        dout_q  <= 1'b0;
                        rcnt_q  <= '0;
                        state_q <= SHIFT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_dout    = dout_q;
    assign spi_dout_oe = oe_q;
    assign cur_ch      = cur_ch_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a bit-banged SPI master with hand-computed replies.
module tb_spi_adc_responder;

    localparam int HALF = 4;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_din;
    logic        spi_dout;
    logic        spi_dout_oe;
    logic [95:0] sample_data;
    logic [2:0]  cur_ch;
    logic        frame_done;
    logic        frame_err;

    logic [15:0] rx;
    int n_chk    = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done0;
    int err0;

    spi_adc_responder #(.SYNC_STAGES(2)) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_din     (spi_din),
        .spi_dout    (spi_dout),
        .spi_dout_oe (spi_dout_oe),
        .sample_data (sample_data),
        .cur_ch      (cur_ch),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [11:0] v);
        sample_data[ch*12 +: 12] = v;
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        cyc(HALF);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        cyc(HALF + 2);
    endtask

    // Clock rises first..last-1 of a frame; master samples dout just before each rise.
    task automatic spi_bits(input logic [15:0] ctrl, input logic [15:0] exp,
                            input int first, input int last, input bit chk_t);
        for (int i = first; i < last; i++) begin
            spi_sclk = 1'b0;
            spi_din  = ctrl[15-i];
            if (chk_t && i > 0) begin
                cyc(2);
                check("t_before", 32'(spi_dout), 32'(exp[16-i]));
                cyc(1);
                check("t_after", 32'(spi_dout), 32'(exp[15-i]));
                cyc(HALF - 3);
            end else begin
                cyc(HALF);
            end
            rx[15-i] = spi_dout;
            spi_sclk = 1'b1;
            cyc(HALF);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        spi_cs_n    = 1'b1;
        spi_sclk    = 1'b1;
        spi_din     = 1'b0;
        sample_data = '0;
        rx          = '0;
        cyc(3);
        check("rst_dout", 32'(spi_dout), 32'd0);
        check("rst_oe", 32'(spi_dout_oe), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        cyc(5);

        // single frame, address 3 selected
        set_ch(0, 12'hA5C);
        set_ch(3, 12'h7FF);
        done0 = done_cnt;
        cs_low();
        check("f1_oe", 32'(spi_dout_oe), 32'd1);
        check("f1_first", 32'(spi_dout), 32'd0);
        spi_bits(16'h1800, 16'h0A5C, 0, 16, 1'b0);
        cs_high();
        check("f1_rx", 32'(rx), 32'h0A5C);
        check("f1_done", 32'(done_cnt - done0), 32'd1);
        check("f1_cur_ch", 32'(cur_ch), 32'd3);
        check("f1_oe_off", 32'(spi_dout_oe), 32'd0);

        // next frame with edge timing and sample_data changed mid-frame
        done0 = done_cnt;
        cs_low();
        spi_bits(16'h0000, 16'h07FF, 0, 8, 1'b1);
        set_ch(3, 12'h000);
        set_ch(0, 12'h3C6);
        spi_bits(16'h0000, 16'h07FF, 8, 16, 1'b1);
        cs_high();
        check("f2_rx", 32'(rx), 32'h07FF);
        check("f2_done", 32'(done_cnt - done0), 32'd1);
        check("f2_cur_ch", 32'(cur_ch), 32'd0);

        // continuous mode: select 5 then 2 without releasing cs
        set_ch(5, 12'h123);
        set_ch(2, 12'hFFF);
        done0 = done_cnt;
        cs_low();
        spi_bits(16'h2800, 16'h03C6, 0, 16, 1'b1);
        check("c1_rx", 32'(rx), 32'h03C6);
        check("c1_cur_ch", 32'(cur_ch), 32'd5);
        spi_bits(16'h1000, 16'h0123, 0, 16, 1'b1);
        check("c2_rx", 32'(rx), 32'h0123);
        cs_high();
        check("c_done", 32'(done_cnt - done0), 32'd2);
        check("c_cur_ch", 32'(cur_ch), 32'd2);

        // aborted after 7 rises
        done0 = done_cnt;
        err0  = err_cnt;
        cs_low();
        spi_bits(16'h3800, 16'h0FFF, 0, 7, 1'b0);
        check("ab_rx_hi", 32'(rx[15:9]), 32'h07);
        spi_cs_n = 1'b1;
        cyc(2);
        check("ab_oe_lat", 32'(spi_dout_oe), 32'd1);
        cyc(1);
        check("ab_oe", 32'(spi_dout_oe), 32'd0);
        check("ab_dout", 32'(spi_dout), 32'd0);
        cyc(HALF);
        check("ab_err", 32'(err_cnt - err0), 32'd1);
        check("ab_done", 32'(done_cnt - done0), 32'd0);
        check("ab_cur_ch", 32'(cur_ch), 32'd2);

        // select then deselect with no rising edges: no pulse
        err0 = err_cnt;
        cs_low();
        check("empty_oe", 32'(spi_dout_oe), 32'd1);
        cs_high();
        check("empty_err", 32'(err_cnt - err0), 32'd0);

        // sclk toggling while idle
        done0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            spi_sclk = 1'b0;
            cyc(HALF);
            spi_sclk = 1'b1;
            cyc(HALF);
        end
        check("idle_oe", 32'(spi_dout_oe), 32'd0);
        check("idle_dout", 32'(spi_dout), 32'd0);
        check("idle_done", 32'(done_cnt - done0), 32'd0);
        check("idle_cur_ch", 32'(cur_ch), 32'd2);

        // reset in the middle of a frame after 9 rises
        err0 = err_cnt;
        cs_low();
        spi_bits(16'h3800, 16'h0FFF, 0, 9, 1'b0);
        check("mr_oe_pre", 32'(spi_dout_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_dout", 32'(spi_dout), 32'd0);
        check("mr_oe", 32'(spi_dout_oe), 32'd0);
        check("mr_cur_ch", 32'(cur_ch), 32'd0);
        check("mr_done", 32'(frame_done), 32'd0);
        check("mr_err", 32'(frame_err), 32'd0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b1;
        cyc(3);
        reset_n = 1'b1;
        cyc(5);
        check("mr_no_err", 32'(err_cnt - err0), 32'd0);
        set_ch(0, 12'h9A1);
        done0 = done_cnt;
        cs_low();
        spi_bits(16'h0000, 16'h09A1, 0, 16, 1'b1);
        cs_high();
        check("mr_rx", 32'(rx), 32'h09A1);
        check("mr_frame_done", 32'(done_cnt - done0), 32'd1);
        check("mr_cur_ch_end", 32'(cur_ch), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_adc_responder.md
SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: the number of clk_50 flops in each input synchronizer, legal range 2..3.
REQ-002 The block SHALL have port clk_50, input, 1 bit: the single system clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port spi_cs_n, input, 1 bit: frame select from the SPI master, asynchronous to clk_50.
REQ-005 The block SHALL have port spi_sclk, input, 1 bit: serial clock from the master, idle high, asynchronous to clk_50.
REQ-006 The block SHALL have port spi_din, input, 1 bit: master control word (the SADDR line), sampled on spi_sclk rising edges.
REQ-007 The block SHALL have port spi_dout, output, 1 bit: serial conversion result, changing on spi_sclk falling edges.
REQ-008 The block SHALL have port spi_dout_oe, output, 1 bit: pad enable for spi_dout, high while the frame is selected.
REQ-009 The block SHALL have port sample_data, input, 96 bits: channel n value at [12n+11:12n], n = 0..7.
REQ-010 The block SHALL have port cur_ch, output, 3 bits: the channel whose value the current or next frame returns.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the 16th rising edge of a frame is detected.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when spi_cs_n rises after 1..15 rising edges of a frame.

Function
REQ-013 spi_cs_n, spi_sclk and spi_din SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized values.
REQ-014 Correct operation SHALL require each spi_sclk high and low phase to be at least 2*SYNC_STAGES clk_50 cycles long.
REQ-015 The state machine SHALL have three states: IDLE, SHIFT and HOLD.
REQ-016 In IDLE, on a detected spi_cs_n fall, the block SHALL:
- load shift register sr[15:0] with {4'b0000, channel cur_ch of sample_data};
- drive spi_dout with sr[15];
- assert spi_dout_oe;
- clear the rising-edge counter rcnt (5 bits);
- enter SHIFT.
REQ-017 In SHIFT, each detected spi_sclk rise SHALL increment rcnt.
REQ-018 In SHIFT, spi_din SHALL be captured into the next-address register when rcnt is 2, 3 or 4 before the increment (control bits DB13..DB11), MSB first.
REQ-019 In SHIFT, each detected spi_sclk fall after at least one rise SHALL shift sr left by one bit and drive the new sr[15] on spi_dout.
REQ-020 When rcnt reaches 16, the block SHALL:
- pulse frame_done;
- copy the next-address register into cur_ch;
- enter HOLD.
REQ-021 In HOLD with spi_cs_n still low, the next spi_sclk fall SHALL reload sr from the updated cur_ch, drive spi_dout with sr[15], clear rcnt and re-enter SHIFT (continuous-frame mode).
REQ-022 In SHIFT or HOLD, a detected spi_cs_n rise SHALL return the block to IDLE, deassert spi_dout_oe and drive spi_dout to 0.
REQ-023 A spi_cs_n rise in SHIFT with rcnt in 1..15 SHALL pulse frame_err and leave cur_ch unchanged.
REQ-024 A spi_cs_n rise with rcnt = 0 SHALL produce no pulse.
REQ-025 spi_sclk edges detected while in IDLE SHALL be ignored.
REQ-026 sample_data SHALL be sampled only at a shift-register load; changes during a frame SHALL not affect the bits already loaded.
REQ-027 spi_dout SHALL change 1+SYNC_STAGES clk_50 cycles after the pin edge that causes the change.
REQ-028 If a spi_cs_n fall and a spi_sclk edge are detected in the same cycle, the spi_cs_n event SHALL take priority and the spi_sclk edge SHALL be ignored.

Reset
REQ-029 While reset_n is low, the block SHALL hold:
- state = IDLE, cur_ch = 0, next-address = 0, sr = 0, rcnt = 0;
- spi_dout = 0, spi_dout_oe = 0, frame_done = 0, frame_err = 0;
- all synchronizer flops = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame without a frame_err pulse.
REQ-031 After reset release, the first frame SHALL begin only on a spi_cs_n fall detected with the synchronizers settled high.

Verification
REQ-032 Single frame: sample_data ch0 = 12'hA5C, master sends control 16'h1800 (address 3) -> spi_dout bits 0000_1010_0101_1100; frame_done pulses once; cur_ch = 3.
REQ-033 Next frame: ch3 = 12'h7FF, control 16'h0000 -> returns 16'h07FF; cur_ch = 0 after the frame.
REQ-034 Continuous mode: spi_cs_n held low for 32 clocks; ch5 = 12'h123, ch2 = 12'hFFF; first control selects 5, second selects 2 -> second half returns 16'h0123; two frame_done pulses; cur_ch = 2.
REQ-035 Aborted frame: spi_cs_n rises after 7 rising edges -> frame_err pulses once; cur_ch unchanged; spi_dout_oe = 0 within 1+SYNC_STAGES cycles.
REQ-036 Reset mid-frame: reset_n low at rcnt = 9 -> all outputs 0 immediately; no frame_err; the next frame returns channel 0.
REQ-037 Timing: spi_sclk phases of exactly 4 clk_50 cycles at SYNC_STAGES = 2, with sample_data changed mid-frame -> frame bits unchanged; each spi_dout transition occurs 3 cycles after the spi_sclk fall.
